// File: rtl/cfg_arb_pkg.sv
// Shared types and helpers for the ConfigMem read-port arbiter.
// Burst locking is compiled in with CFG_ARB_LOCK_EN.
package cfg_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // ConfigMem registers its read data once
    localparam int RD_LAT  = 1;
    localparam int MAX_REQ = 8;

    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        logic [3:0]         idx;
        logic               found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                idx = {1'b0, ptr} + 4'(i);
                if (idx >= 4'(n)) idx = idx - 4'(n);
                if (!found && req[idx[2:0]]) begin
                    gnt[idx[2:0]] = 1'b1;
                    found         = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/config_rd_arbiter_rr_prio_sel.sv
// Round-robin selector: rotate by ptr, take the lowest set bit, rotate back.
module rr_prio_sel #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt
);

    logic [2*NUM_REQ-1:0] rot_dbl;
    logic [2*NUM_REQ-1:0] back_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [NUM_REQ-1:0]   pick;

    always_comb begin
        rot_dbl = {req, req} >> ptr;
        rot     = rot_dbl[NUM_REQ-1:0];
        pick    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        back_dbl = {pick, pick} << ptr;
        gnt      = back_dbl[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/config_rd_arbiter.sv
// Round-robin arbiter sharing one ConfigMem read port; tags reads per owner.
// Define CFG_ARB_LOCK_EN to enable bounded burst locking via lock_i.
module config_rd_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 8,
    parameter int LOCK_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rsp_vld_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic                      mem_rdEn_o,
    output logic                      busy_o
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               lock_nxt;
    logic [NUM_REQ-1:0] rsp_pipe [RD_LAT];

    rr_prio_sel #(
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .req (arb_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

`ifdef CFG_ARB_LOCK_EN
    state_t         state;
    logic [PW-1:0]  owner;
    logic [CNT_W-1:0] lock_cnt;
    logic           in_lock;
    logic           forced;
    logic           hold;

    assign in_lock = (state == LOCKED);
    assign forced  = in_lock && (lock_cnt == CNT_W'(LOCK_MAX));
    assign hold    = in_lock && !forced && req_i[owner] && lock_i[owner];

    // Forced release masks the owner for one arbitration round
    always_comb begin
        arb_req = req_i;
        if (forced) arb_req[owner] = 1'b0;
    end

    always_comb begin
        gnt = arb_gnt;
        if (hold) begin
            gnt        = '0;
            gnt[owner] = 1'b1;
        end
    end

    assign lock_nxt = |(gnt & lock_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            owner    <= '0;
            lock_cnt <= '0;
        end else if (hold) begin
            lock_cnt <= lock_cnt + 1'b1;
        end else if (lock_nxt) begin
            state    <= LOCKED;
            owner    <= gnt_idx;
            lock_cnt <= CNT_W'(1);
        end else begin
            state    <= IDLE;
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;
    localparam logic [CNT_W-1:0] unused_cnt = CNT_W'(LOCK_MAX);

    assign unused_lock = ^{lock_i, unused_cnt};
    assign arb_req     = req_i;
    assign gnt         = arb_gnt;
    assign lock_nxt    = 1'b0;
`endif

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    assign ptr_nxt = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    assign gnt_o      = rst_n_i ? gnt : '0;
    assign mem_rdEn_o = |gnt_o;

    always_comb begin
        mem_addr_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            mem_addr_o = mem_addr_o
                       | (addr_i[k*ADDR_W +: ADDR_W] & {ADDR_W{gnt_o[k]}});
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr <= '0;
            busy_o <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) rsp_pipe[i] <= '0;
        end else begin
            if (|gnt_o) rr_ptr <= ptr_nxt;
            busy_o      <= (|gnt_o) | lock_nxt;
            rsp_pipe[0] <= gnt_o;
            for (int i = 1; i < RD_LAT; i++) rsp_pipe[i] <= rsp_pipe[i-1];
        end
    end

    assign rsp_vld_o = rsp_pipe[RD_LAT-1];

endmodule

// File: tb/tb_config_rd_arbiter.sv
// Bench for config_rd_arbiter: 2-requester and 4-requester instances.
// Lock scenarios run only when CFG_ARB_LOCK_EN is defined.
module tb_config_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  req_a, lock_a, gnt_a, rsp_a;
    logic [15:0] addr_a;
    logic [7:0]  maddr_a;
    logic        rd_a, busy_a;

    logic [3:0]  req_b, lock_b, gnt_b, rsp_b;
    logic [31:0] addr_b;
    logic [7:0]  maddr_b;
    logic        rd_b, busy_b;

    logic [1:0]  exp_q [$];
    logic [3:0]  expb_q [$];
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    config_rd_arbiter #(
        .NUM_REQ (2), .ADDR_W (8), .LOCK_MAX (4), .CNT_W (3)
    ) dut_a (
        .clk_i (clk), .rst_n_i (rst_n), .req_i (req_a), .addr_i (addr_a),
        .lock_i (lock_a), .gnt_o (gnt_a), .rsp_vld_o (rsp_a),
        .mem_addr_o (maddr_a), .mem_rdEn_o (rd_a), .busy_o (busy_a)
    );

    config_rd_arbiter #(
        .NUM_REQ (4), .ADDR_W (8)
    ) dut_b (
        .clk_i (clk), .rst_n_i (rst_n), .req_i (req_b), .addr_i (addr_b),
        .lock_i (lock_b), .gnt_o (gnt_b), .rsp_vld_o (rsp_b),
        .mem_addr_o (maddr_b), .mem_rdEn_o (rd_b), .busy_o (busy_b)
    );

    task automatic run_a(input string name, input logic [1:0] rq [],
                         input logic [1:0] lk [], input logic [1:0] eg [],
                         input logic eb [], input bit chk_busy);
        logic [1:0] er;
        logic [7:0] ea;
        for (int i = 0; i < rq.size(); i++) begin
            req_a  = rq[i];
            lock_a = lk[i];
            #1;
            ea = eg[i][0] ? addr_a[7:0] : (eg[i][1] ? addr_a[15:8] : 8'h00);
            checks++;
            if (gnt_a !== eg[i]) begin
                fails++;
                $display("FAIL %s gnt c%0d: got %b want %b", name, i, gnt_a, eg[i]);
            end
            checks++;
            if (maddr_a !== ea) begin
                fails++;
                $display("FAIL %s addr c%0d: got %h want %h", name, i, maddr_a, ea);
            end
            checks++;
            if (rd_a !== (|eg[i])) begin
                fails++;
                $display("FAIL %s rdEn c%0d: got %b want %b", name, i, rd_a, |eg[i]);
            end
            exp_q.push_back(eg[i]);
            @(posedge clk);
            #1;
            er = exp_q.pop_front();
            checks++;
            if (rsp_a !== er) begin
                fails++;
                $display("FAIL %s rsp c%0d: got %b want %b", name, i, rsp_a, er);
            end
            if (chk_busy) begin
                checks++;
                if (busy_a !== eb[i]) begin
                    fails++;
                    $display("FAIL %s busy c%0d: got %b want %b", name, i, busy_a, eb[i]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [1:0] rq [] = '{2'b11, 2'b11, 2'b11};
        logic [1:0] eg [] = '{2'b01, 2'b10, 2'b01};
        logic [1:0] rq2 [] = '{2'b11, 2'b11, 2'b00};
        logic [1:0] eg2 [] = '{2'b01, 2'b10, 2'b00};
        logic [1:0] lk [] = '{2'b00, 2'b00, 2'b00};
        logic       eb [] = '{1'b0, 1'b0, 1'b0};
        rst_n = 1'b0;
        req_a = '0; lock_a = '0; addr_a = 16'h2010;
        req_b = '0; lock_b = '0; addr_b = 32'h4342_4140;
        #1;
        checks++;
        if ({gnt_a, rsp_a, rd_a, busy_a} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outs: got %b want 000000", {gnt_a, rsp_a, rd_a, busy_a});
        end
        checks++;
        if (maddr_a !== 8'h00) begin
            fails++;
            $display("FAIL reset_addr: got %h want 00", maddr_a);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_a("pre_reset", rq, lk, eg, eb, 1'b0);
        req_a = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt_a !== 2'b00 || rd_a !== 1'b0) begin
            fails++;
            $display("FAIL midreset_gnt: got %b/%b want 00/0", gnt_a, rd_a);
        end
        checks++;
        if (rsp_a !== 2'b00) begin
            fails++;
            $display("FAIL midreset_rsp: got %b want 00", rsp_a);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if (rsp_a !== 2'b00 || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_cycle_rsp: got %b/%b want 00/0", rsp_a, busy_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_a("post_reset", rq2, lk, eg2, eb, 1'b0);
    endtask

    task automatic test_alternate();
        logic [1:0] rq [] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [1:0] eg [] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [1:0] lk [] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic       eb [] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        addr_a = 16'h2010;
        run_a("alternate", rq, lk, eg, eb, 1'b1);
    endtask

    task automatic test_single();
        logic [1:0] rq [] = '{2'b10, 2'b00, 2'b11, 2'b00};
        logic [1:0] eg [] = '{2'b10, 2'b00, 2'b01, 2'b00};
        logic [1:0] lk [] = '{2'b00, 2'b00, 2'b00, 2'b00};
        logic       eb [] = '{1'b1, 1'b0, 1'b1, 1'b0};
        addr_a = 16'hA533;
        run_a("single", rq, lk, eg, eb, 1'b1);
    endtask

`ifdef CFG_ARB_LOCK_EN
    task automatic test_lock_forced();
        logic [1:0] rq [] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [1:0] lk [] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic [1:0] eg [] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
        logic       eb [] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        addr_a = 16'h2010;
        run_a("lock_forced", rq, lk, eg, eb, 1'b1);
    endtask

    task automatic test_lock_drop();
        logic [1:0] rq [] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [1:0] lk [] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] eg [] = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        logic       eb [] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        addr_a = 16'h2010;
        run_a("lock_drop", rq, lk, eg, eb, 1'b1);
    endtask
`else
    task automatic test_lock_ignored();
        logic [1:0] rq [] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        logic [1:0] lk [] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        logic [1:0] eg [] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        logic       eb [] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        addr_a = 16'h2010;
        run_a("lock_ignored", rq, lk, eg, eb, 1'b1);
    endtask
`endif

    task automatic test_four_req();
        logic [3:0] rq [] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1111,
                              4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] eg [] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        logic [3:0] er;
        logic [7:0] ea;
        addr_b = 32'h4342_4140;
        for (int i = 0; i < rq.size(); i++) begin
            req_b = rq[i];
            #1;
            ea = 8'h00;
            for (int k = 0; k < 4; k++) if (eg[i][k]) ea = 8'h40 + 8'(k);
            checks++;
            if (gnt_b !== eg[i]) begin
                fails++;
                $display("FAIL four gnt c%0d: got %b want %b", i, gnt_b, eg[i]);
            end
            checks++;
            if (maddr_b !== ea || rd_b !== (|eg[i])) begin
                fails++;
                $display("FAIL four addr c%0d: got %h/%b want %h/%b",
                         i, maddr_b, rd_b, ea, |eg[i]);
            end
            expb_q.push_back(eg[i]);
            @(posedge clk);
            #1;
            er = expb_q.pop_front();
            checks++;
            if (rsp_b !== er) begin
                fails++;
                $display("FAIL four rsp c%0d: got %b want %b", i, rsp_b, er);
            end
            @(negedge clk);
        end
        checks++;
        if (busy_b !== 1'b0) begin
            fails++;
            $display("FAIL four busy_idle: got %b want 0", busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
`ifdef CFG_ARB_LOCK_EN
        test_lock_forced();
        test_lock_drop();
`else
        test_lock_ignored();
`endif
        test_four_req();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
